load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum bus-wait cycles before a bus error is declared (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to execute one memory access; sampled only in IDLE.
REQ-005 is_load  input  1  access is a load.
REQ-006 is_store  input  1  access is a store.
REQ-007 funct3  input  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 addr  input  32  effective byte address (ALU Result).
REQ-009 wdata  input  32  store source (rs2 value).
REQ-010 mem_req  output  1  bus request, held until accepted.
REQ-011 mem_we  output  1  1 = write, 0 = read.
REQ-012 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-013 mem_be  output  4  byte enables.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_ready  input  1  bus accepts/completes the access this cycle.
REQ-016 mem_rdata  input  32  read word, valid when mem_ready=1.
REQ-017 busy  output  1  unit not in IDLE; core stalls on it.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 rdata  output  32  extended load result, valid with done.
REQ-020 misaligned  output  1  access misaligned, valid with done.
REQ-021 bus_err  output  1  illegal access or timeout, valid with done.

Function
REQ-022 States IDLE, REQ, DONE; busy = (state != IDLE).
REQ-023 IDLE: start=1 latches is_load, is_store, funct3, addr, wdata into internal registers; next state REQ if legal and aligned, else DONE.
REQ-024 Illegal: is_load==is_store, or funct3 not in {000,001,010} for stores / {000,001,010,100,101} for loads -> DONE with bus_err=1, no mem_req.
REQ-025 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0 -> DONE with misaligned=1, bus_err=0, no mem_req.
REQ-026 REQ: mem_req=1, mem_we=latched is_store; mem_addr/mem_be/mem_wdata stable for whole REQ state.
REQ-027 Byte enables: B -> 4'b0001<<addr[1:0]; H -> addr[1]?1100:0011; W -> 1111; loads drive the same mask.
REQ-028 Store data: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
REQ-029 REQ with mem_ready=1 at edge: capture extended load data, next state DONE; minimum start-to-done latency 2 cycles (start at edge N, mem_req in cycle N+1, done in cycle N+2 with immediate ready).
REQ-030 Load extraction: select byte addr[1:0] / halfword addr[1]; B, H sign-extend; BU, HU zero-extend; W unchanged.
REQ-031 Wait counter clears on REQ entry, increments each REQ cycle with mem_ready=0; reaching TIMEOUT -> DONE with bus_err=1, rdata=0; mem_ready in the same cycle as the count reaching TIMEOUT wins (normal completion).
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; start is ignored in REQ and DONE (not queued).
REQ-033 rdata, misaligned, bus_err hold their values until the next done; rdata=0 for stores and errored accesses.
REQ-034 mem_req, mem_we, mem_be are 0 in IDLE and DONE.

Reset
REQ-035 rst_n=0 at an edge forces IDLE; busy, done, mem_req, mem_we, misaligned, bus_err = 0; mem_be = 0; rdata, mem_addr, mem_wdata, wait counter = 0.
REQ-036 Reset mid-access (REQ state) drops mem_req at that edge; no done pulse for the aborted access.

Verification
REQ-037 LB addr=0x1003, mem_rdata=0x80FF_FFFF, ready immediately -> mem_be=1000, done 2 cycles after start, rdata=0xFFFF_FF80.
REQ-038 SH addr=0x2002, wdata=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x2000.
REQ-039 LW addr=0x3001 -> no mem_req, done next cycle with misaligned=1, bus_err=0.
REQ-040 LHU addr=0x4002, mem_ready held low 3 cycles then high with 0xBEEF_0000 -> mem_req 4 cycles, rdata=0x0000_BEEF.
REQ-041 TIMEOUT=4, mem_ready never asserted -> done after 4 REQ cycles, bus_err=1, rdata=0.
REQ-042 rst_n=0 during REQ, start pulsed in REQ and DONE -> mem_req=0 after reset edge, no done; mid-access start ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one outstanding request, held until
// mem_ready; the unit drives the request side, the memory drives the response.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: latches one access, checks legality and alignment,
// runs a single bus transaction with a wait timeout and returns extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    load_store_unit_if.master        mem,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              rdata,
    output logic                     misaligned,
    output logic                     bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        op_store;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [7:0]  wait_cnt;

    logic        legal;
    logic        mis;
    logic        timeout_hit;
    logic [3:0]  be_in;
    logic [31:0] wdata_rep;

    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = word;
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = '0;
        endcase
    endfunction

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        legal     = 1'b0;
        mis       = 1'b0;
        be_in     = 4'b1111;
        wdata_rep = wdata;
        if (is_load != is_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b100, 3'b101:         legal = is_load;
                default:                legal = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b00: begin
                be_in     = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_in     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                mis       = addr[0];
            end
            default: begin
                be_in = 4'b1111;
                mis   = (addr[1:0] != 2'b00);
            end
        endcase
    end

    assign timeout_hit = (wait_cnt == LAST_WAIT);

    // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (legal && !mis) ? REQ : DONE;
            REQ:     if (mem.mem_ready || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = (state == REQ) && op_store;
    assign mem.mem_be    = (state == REQ) ? be_q : 4'b0000;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Result flags change only on entry to DONE, so they hold between accesses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_store   <= 1'b0;
            op_f3      <= '0;
            op_off     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wait_cnt   <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_store <= is_store;
                        op_f3    <= funct3;
                        op_off   <= addr[1:0];
                        addr_q   <= {addr[31:2], 2'b00};
                        wdata_q  <= wdata_rep;
                        be_q     <= be_in;
                        wait_cnt <= '0;
                        if (!legal) begin
                            rdata      <= '0;
                            misaligned <= 1'b0;
                            bus_err    <= 1'b1;
                        end else if (mis) begin
                            rdata      <= '0;
                            misaligned <= 1'b1;
                            bus_err    <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        rdata      <= op_store ? 32'd0 : load_ext(op_f3, op_off, mem.mem_rdata);
                        misaligned <= 1'b0;
                        bus_err    <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata      <= '0;
                        misaligned <= 1'b0;
                        bus_err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: a transaction-level model predicts bus
// activity and results; a negedge process compares every cycle.
module tb_load_store_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .mem        (mem_bus),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          has_req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
        logic [31:0] rdata;
        bit          mis;
        bit          err;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle outputs, set by the driver, compared at negedge.
    bit          chk_en = 1'b0;
    logic        e_busy, e_done, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic [31:0] r_rdata;
    logic        r_mis, r_err;

    // Observations of the last transaction, for directed literal checks.
    int          obs_req;
    int          obs_done_k;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] w,
                                   input int delay, input logic [31:0] word);
        exp_t            e;
        bit              legal;
        int              size, off;
        longint unsigned v, lim;
        e = '{default: '0};
        legal = (ld != st) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                               (ld && (f3 == 3'd4 || f3 == 3'd5)));
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a % 32'd4);
        e.err = !legal;
        e.mis = legal && (off % size != 0);
        e.has_req = legal && !e.mis;
        if (e.has_req) begin
            e.we    = st;
            e.addr  = a - 32'(off);
            e.be    = 4'(((1 << size) - 1) << off);
            e.wdata = (size == 1) ? 32'(w[7:0]) * 32'h0101_0101 :
                      (size == 2) ? 32'(w[15:0]) * 32'h0001_0001 : w;
            if (delay >= TIMEOUT) begin
                e.req_cycles = TIMEOUT;
                e.err        = 1'b1;
            end else begin
                e.req_cycles = delay + 1;
                if (ld) begin
                    lim = 64'd1 << (8 * size);
                    v   = (64'(word) >> (8 * off)) % lim;
                    if (!f3[2] && size < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
                    e.rdata = 32'(v);
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       32'(busy),             32'(e_busy));
            check("done",       32'(done),             32'(e_done));
            check("mem_req",    32'(mem_bus.mem_req),  32'(e_req));
            check("mem_we",     32'(mem_bus.mem_we),   32'(e_we));
            check("mem_be",     32'(mem_bus.mem_be),   32'(e_be));
            check("rdata",      rdata,                 r_rdata);
            check("misaligned", 32'(misaligned),       32'(r_mis));
            check("bus_err",    32'(bus_err),          32'(r_err));
            if (e_req) check("mem_addr", mem_bus.mem_addr, e_addr);
            if (e_req && e_we) check("mem_wdata", mem_bus.mem_wdata, e_wdata);
        end
    end

    task automatic set_idle_exp();
        e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_we = 1'b0; e_be = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        start = 1'b0;
        set_idle_exp();
    endtask

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
    task automatic txn(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w,
                       input int delay, input logic [31:0] word, input bit noisy);
        exp_t e;
        int   last;
        e = model(ld, st, f3, a, w, delay, word);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = w;
        set_idle_exp();
        obs_req = 0; obs_done_k = 0; obs_we = 1'b0; obs_be = '0; obs_addr = '0; obs_wdata = '0;
        last = e.has_req ? e.req_cycles + 1 : 1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                is_load = 1'($urandom); is_store = 1'($urandom);
                funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            end
            if (mem_bus.mem_req) begin
                obs_req++;
                obs_we = mem_bus.mem_we; obs_be = mem_bus.mem_be;
                obs_addr = mem_bus.mem_addr; obs_wdata = mem_bus.mem_wdata;
            end
            if (done && obs_done_k == 0) obs_done_k = k;
            if (k < last) begin
                e_busy = 1'b1; e_done = 1'b0; e_req = 1'b1; e_we = e.we;
                e_be = e.be; e_addr = e.addr; e_wdata = e.wdata;
                mem_bus.mem_ready = (k == delay + 1);
                mem_bus.mem_rdata = (k == delay + 1) ? word : $urandom;
            end else begin
                e_busy = 1'b1; e_done = 1'b1; e_req = 1'b0; e_we = 1'b0; e_be = '0;
                r_rdata = e.rdata; r_mis = e.mis; r_err = e.err;
                mem_bus.mem_ready = 1'b0;
            end
        end
        idle_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        m;
        logic [2:0]  f3_list [5];
        bit          ld, st;
        logic [2:0]  f3;
        f3_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; addr = '0; wdata = '0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
        r_rdata = '0; r_mis = 1'b0; r_err = 1'b0;
        set_idle_exp();
        e_addr = '0; e_wdata = '0;

        // Reset state, with start asserted to show it cannot leave IDLE under reset.
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        chk_en = 1'b1;
        check("rst_mem_addr",  mem_bus.mem_addr,  32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        idle_cycle();

        // Pin the model with hand-computed values.
        m = model(1, 0, 3'b000, 32'h1003, 32'h0, 0, 32'h80FF_FFFF);
        check("model_lb_rdata", m.rdata, 32'hFFFF_FF80);
        m = model(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 0, 32'h0);
        check("model_sh_wdata", m.wdata, 32'hABCD_ABCD);
        check("model_sh_be",    32'(m.be), 32'h0000_000C);

        // LB with sign extension, immediate ready.
        txn(1, 0, 3'b000, 32'h1003, $urandom, 0, 32'h80FF_FFFF, 0);
        check("lb_be",      32'(obs_be), 32'h8);
        check("lb_latency", obs_done_k,  2);
        check("lb_rdata",   rdata,       32'hFFFF_FF80);

        // SH with lane replication.
        txn(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 0, 32'h0, 0);
        check("sh_we",    32'(obs_we),  32'h1);
        check("sh_be",    32'(obs_be),  32'hC);
        check("sh_wdata", obs_wdata,    32'hABCD_ABCD);
        check("sh_addr",  obs_addr,     32'h2000);
        check("sh_rdata", rdata,        32'h0);

        // Misaligned LW: no bus request, done next cycle.
        txn(1, 0, 3'b010, 32'h3001, 32'h0, 0, 32'h0, 0);
        check("lw_mis_req",  obs_req,           0);
        check("lw_mis_done", obs_done_k,        1);
        check("lw_mis_flag", 32'(misaligned),   32'h1);
        check("lw_mis_err",  32'(bus_err),      32'h0);

        // LHU with three wait cycles.
        txn(1, 0, 3'b101, 32'h4002, 32'h0, 3, 32'hBEEF_0000, 0);
        check("lhu_req_cycles", obs_req, 4);
        check("lhu_rdata",      rdata,   32'h0000_BEEF);

        // Timeout: ready never comes.
        txn(1, 0, 3'b010, 32'h5000, 32'h0, 100, 32'hFFFF_FFFF, 0);
        check("to_req_cycles", obs_req,       TIMEOUT);
        check("to_done",       obs_done_k,    TIMEOUT + 1);
        check("to_err",        32'(bus_err),  32'h1);
        check("to_rdata",      rdata,         32'h0);

        // Ready on the last allowed wait cycle beats the timeout.
        txn(1, 0, 3'b010, 32'h6000, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 0);
        check("edge_err",   32'(bus_err), 32'h0);
        check("edge_rdata", rdata,        32'hCAFE_F00D);

        // Illegal: both load and store, and a store with an unsigned width code.
        txn(1, 1, 3'b010, 32'h7000, 32'h0, 0, 32'h0, 0);
        check("ill_req", obs_req,       0);
        check("ill_err", 32'(bus_err),  32'h1);
        txn(0, 1, 3'b100, 32'h7004, 32'h0, 0, 32'h0, 0);
        check("ill_st_err", 32'(bus_err), 32'h1);

        // Reset in REQ with start pulsed mid-access.
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h100; wdata = $urandom;
        set_idle_exp();
        @(posedge clk); #1;
        start = 1'b1;
        e_busy = 1'b1; e_req = 1'b1; e_we = 1'b0; e_be = 4'hF; e_addr = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_idle_exp();
        r_rdata = '0; r_mis = 1'b0; r_err = 1'b0;
        check("rr_mem_req",  32'(mem_bus.mem_req), 32'h0);
        check("rr_mem_addr", mem_bus.mem_addr,     32'h0);
        repeat (3) idle_cycle();

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            ld = 1'($urandom);
            st = ($urandom_range(0, 9) == 0) ? ld : !ld;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3_list[$urandom_range(0, 4)];
            txn(ld, st, f3, $urandom, $urandom, $urandom_range(0, TIMEOUT + 2),
                $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
